// File: rtl/rst_req.sv
// Reset request generator: debounced button, software key write and watchdog expiry raise a stretched rst_req_out.
// Latency: event -> rst_req_out high on the next cycle; IO access -> ack/data_out exactly one cycle after stb.
// Backpressure: none; every access is acknowledged, and events seen while a request is active are dropped.
module rst_req #(
  parameter int DEBOUNCE_BITS = 20,
  parameter int PULSE_LEN     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_in,
  input  logic        wd_timeout,
  input  logic        stb,
  input  logic        wr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        rst_req_out
);

  typedef enum logic [1:0] {IDLE, PULSE, RELEASE} state_t;

  localparam logic [7:0] PCNT_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0] SW_KEY    = 8'h5A;

  // Button synchroniser and debouncer state
  logic                     btn_s1;
  logic                     btn_s2;
  logic [1:0]               sync_vld;
  logic                     btn_armed;
  logic [DEBOUNCE_BITS-1:0] deb_cnt;
  logic                     deb_lvl;
  logic                     deb_prev;

  // FSM and cause state
  state_t     state;
  logic [7:0] pcnt;
  logic [3:0] cause;

  // Event decode
  logic       btn_evt;
  logic       sw_key;
  logic       sw_evt;
  logic       clr_wr;
  logic       any_evt;
  logic [3:0] cause_set;
  logic [3:0] cause_clr;
  logic       unused_data;

  // Only the key byte and the clear mask of a write carry meaning.
  assign unused_data = ^data_in[23:4];

  // A button event is the rising edge of the debounced level, but only once
  // the synchronised button has been seen low since reset; a button held
  // through reset must be released and pressed again.
  assign btn_evt   = deb_lvl & ~deb_prev & btn_armed;
  assign sw_key    = (data_in[31:24] == SW_KEY);
  assign sw_evt    = stb & wr & sw_key;
  assign clr_wr    = stb & wr & ~sw_key;
  assign any_evt   = btn_evt | sw_evt | wd_timeout;

  // Causes are only captured when a new request actually starts.
  assign cause_set = (state == IDLE) ? {1'b0, wd_timeout, sw_evt, btn_evt} : 4'b0000;
  assign cause_clr = clr_wr ? data_in[3:0] : 4'b0000;

  // Two-flop synchroniser for the raw button, plus a validity shift that
  // marks when btn_s2 holds a real sample rather than its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      sync_vld <= 2'b00;
    end else begin
      btn_s1   <= btn_in;
      btn_s2   <= btn_s1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // Arm button events once a genuine low level has been observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_armed <= 1'b0;
    end else if (sync_vld[1] && !btn_s2) begin
      btn_armed <= 1'b1;
    end
  end

  // Debounce: count only while the synchronised level disagrees with the
  // debounced level; any agreement (a bounce back) restarts the count, and a
  // full count adopts the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt  <= '0;
      deb_lvl  <= 1'b0;
      deb_prev <= 1'b0;
    end else begin
      deb_prev <= deb_lvl;
      if (btn_s2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (&deb_cnt) begin
        deb_lvl <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Request FSM: IDLE waits for an event, PULSE holds the minimum width,
  // RELEASE extends the request while the button stays pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pcnt        <= 8'd0;
      rst_req_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_evt) begin
            state       <= PULSE;
            pcnt        <= 8'd0;
            rst_req_out <= 1'b1;
          end
        end
        PULSE: begin
          if (pcnt == PCNT_LAST) begin
            if (deb_lvl) begin
              state <= RELEASE;
            end else begin
              state       <= IDLE;
              rst_req_out <= 1'b0;
            end
          end else begin
            pcnt <= pcnt + 8'd1;
          end
        end
        RELEASE: begin
          if (!deb_lvl) begin
            state       <= IDLE;
            rst_req_out <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rst_req_out <= 1'b0;
        end
      endcase
    end
  end

  // Cause register: power-on bit set by reset; a same-cycle set beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause <= 4'b1000;
    end else begin
      cause <= (cause & ~cause_clr) | cause_set;
    end
  end

  // IO response: one-cycle ack, read data is the cause seen in the stb cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack      <= 1'b0;
      data_out <= 32'd0;
    end else begin
      ack      <= stb;
      data_out <= (stb && !wr) ? {28'd0, cause} : 32'd0;
    end
  end

endmodule

// File: tb/tb_rst_req.sv
// Directed bench for rst_req with DEBOUNCE_BITS=4, PULSE_LEN=8.
// Read expectations are queued when an access is driven and popped on ack.
// Pulse widths and event counts are measured against fixed constants.
module tb_rst_req;

  logic        clk;
  logic        rst;
  logic        btn_in;
  logic        wd_timeout;
  logic        stb;
  logic        wr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        rst_req_out;

  int          n_assert;
  int          n_fail;
  logic [31:0] exp_q[$];

  rst_req #(.DEBOUNCE_BITS(4), .PULSE_LEN(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .wd_timeout (wd_timeout),
    .stb        (stb),
    .wr         (wr),
    .data_in    (data_in),
    .data_out   (data_out),
    .ack        (ack),
    .rst_req_out(rst_req_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access cycle; the expected response is queued at drive time.
  task automatic do_acc(input logic w, input logic [31:0] d, input logic wd,
                        input logic [31:0] exp_rd, input string tag);
    stb        = 1'b1;
    wr         = w;
    data_in    = d;
    wd_timeout = wd;
    exp_q.push_back(w ? 32'h0 : exp_rd);
    tick();
    stb        = 1'b0;
    wr         = 1'b0;
    data_in    = 32'h0;
    wd_timeout = 1'b0;
    chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      chk(tag, data_out, exp_q.pop_front());
    end
  endtask

  // Count consecutive high samples of rst_req_out; optionally fire a
  // watchdog pulse at a given offset into the request.
  task automatic measure(input int wd_at, output int len);
    len = 0;
    while (rst_req_out === 1'b1 && len < 100) begin
      wd_timeout = (len == wd_at);
      tick();
      len++;
    end
    wd_timeout = 1'b0;
  endtask

  initial begin
    int   len;
    int   ev;
    int   waited;
    logic prev;

    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    btn_in     = 1'b0;
    wd_timeout = 1'b0;
    stb        = 1'b0;
    wr         = 1'b0;
    data_in    = 32'h0;

    // Reset state
    tick(); tick(); tick();
    chk("reset_rst_req_out", {31'd0, rst_req_out}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_ack", {31'd0, ack}, 32'd0);

    // Power-up read
    do_acc(1'b0, 32'h0, 1'b0, 32'h8, "powerup_read");
    chk("powerup_rst_req_out", {31'd0, rst_req_out}, 32'd0);

    // Bouncing button then a held press
    ev   = 0;
    prev = rst_req_out;
    for (int i = 0; i < 40; i++) begin
      btn_in = ((i / 3) % 2 == 0);
      tick();
      if (rst_req_out && !prev) ev++;
      prev = rst_req_out;
    end
    chk("bounce_no_early_event", ev, 0);
    btn_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rst_req_out && !prev) ev++;
      prev = rst_req_out;
    end
    chk("btn_held_high", {31'd0, rst_req_out}, 32'd1);
    btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rst_req_out && !prev) ev++;
      prev = rst_req_out;
    end
    chk("btn_release_still_high", {31'd0, rst_req_out}, 32'd1);
    waited = 0;
    while (rst_req_out === 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    chk("btn_release_fell", {31'd0, rst_req_out}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rst_req_out && !prev) ev++;
      prev = rst_req_out;
    end
    chk("bounce_event_count", ev, 1);
    do_acc(1'b0, 32'h0, 1'b0, 32'h9, "btn_cause_read");

    // Clear all causes
    do_acc(1'b1, 32'h0000000F, 1'b0, 32'h0, "clear_all_write");
    do_acc(1'b0, 32'h0, 1'b0, 32'h0, "clear_all_read");
    chk("clear_no_request", {31'd0, rst_req_out}, 32'd0);

    // Software request
    do_acc(1'b1, 32'h5A000000, 1'b0, 32'h0, "sw_write");
    chk("sw_next_cycle_high", {31'd0, rst_req_out}, 32'd1);
    measure(-1, len);
    chk("sw_pulse_len", len, 8);
    do_acc(1'b0, 32'h0, 1'b0, 32'h2, "sw_cause_read");
    do_acc(1'b1, 32'h00000002, 1'b0, 32'h0, "sw_clear_write");
    do_acc(1'b0, 32'h0, 1'b0, 32'h0, "sw_clear_read");

    // Simultaneous watchdog and software, second watchdog inside the pulse
    do_acc(1'b1, 32'h5A000000, 1'b1, 32'h0, "simul_write");
    chk("simul_next_cycle_high", {31'd0, rst_req_out}, 32'd1);
    measure(2, len);
    chk("simul_pulse_len", len, 8);
    tick(); tick();
    chk("simul_no_restart", {31'd0, rst_req_out}, 32'd0);
    do_acc(1'b0, 32'h0, 1'b0, 32'h6, "simul_cause_read");

    // Clear racing a watchdog set: set wins
    do_acc(1'b1, 32'h0000000F, 1'b0, 32'h0, "clear2_write");
    do_acc(1'b0, 32'h0, 1'b0, 32'h0, "clear2_read");
    do_acc(1'b1, 32'h00000004, 1'b1, 32'h0, "race_write");
    measure(-1, len);
    chk("race_pulse_len", len, 8);
    do_acc(1'b0, 32'h0, 1'b0, 32'h4, "race_cause_read");

    // Reset in the third cycle of a pulse
    do_acc(1'b1, 32'h5A000000, 1'b0, 32'h0, "midrst_write");
    tick(); tick();
    chk("midrst_high_before", {31'd0, rst_req_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_immediate_drop", {31'd0, rst_req_out}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("midrst_after_release", {31'd0, rst_req_out}, 32'd0);
    do_acc(1'b0, 32'h0, 1'b0, 32'h8, "midrst_cause_read");

    // Button held across reset must not retrigger
    btn_in = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("held_pre_reset_high", {31'd0, rst_req_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("held_reset_drop", {31'd0, rst_req_out}, 32'd0);
    tick(); tick();
    rst  = 1'b0;
    ev   = 0;
    prev = rst_req_out;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rst_req_out && !prev) ev++;
      prev = rst_req_out;
    end
    chk("held_no_event", ev, 0);
    do_acc(1'b0, 32'h0, 1'b0, 32'h8, "held_cause_read");
    btn_in = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    btn_in = 1'b1;
    waited = 0;
    while (rst_req_out !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    chk("repress_event", {31'd0, rst_req_out}, 32'd1);
    btn_in = 1'b0;
    waited = 0;
    while (rst_req_out === 1'b1 && waited < 80) begin
      tick();
      waited++;
    end
    chk("repress_fell", {31'd0, rst_req_out}, 32'd0);
    do_acc(1'b0, 32'h0, 1'b0, 32'h9, "repress_cause_read");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
